// File: rtl/vga_pic_bounce.sv
// Bouncing-box picture generator: returns one RGB444 pixel per requested
// coordinate with a single cycle of latency, and moves a coloured square one
// STEP per frame, bouncing off the active-area edges and changing colour on
// every bounce.
module vga_pic_bounce #(
    parameter logic [9:0]  H_VALID  = 10'd640,
    parameter logic [9:0]  V_VALID  = 10'd480,
    parameter logic [9:0]  BOX_SIZE = 10'd32,
    parameter logic [9:0]  STEP     = 10'd1,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pause,
    output logic [11:0] pix_data,
    output logic        frame_tick,
    output logic [2:0]  color_idx
);

    localparam logic [9:0]  NO_REQ = 10'h3FF;
    // Furthest legal top-left corner on each axis, kept at 11 bits.
    localparam logic [10:0] X_LIM  = {1'b0, H_VALID} - {1'b0, BOX_SIZE};
    localparam logic [10:0] Y_LIM  = {1'b0, V_VALID} - {1'b0, BOX_SIZE};
    localparam logic [10:0] STEP_W = {1'b0, STEP};
    localparam logic [10:0] SIZE_W = {1'b0, BOX_SIZE};

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;     // 1 = increasing coordinate
        logic       bounce;
    } axis_t;

    logic [9:0] box_x, box_y;
    logic       dir_x, dir_y;
    axis_t      nxt_x, nxt_y;
    logic       in_box;
    logic [11:0] box_color;

    // One axis of motion: advance by STEP, clamping to the wall and turning
    // around when the wall would be reached or crossed.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic dir,
                                        input logic [10:0] lim);
        axis_t r;
        r.pos    = pos;
        r.dir    = dir;
        r.bounce = 1'b0;
        if (dir) begin
            if ({1'b0, pos} + STEP_W >= lim) begin
                r.pos    = lim[9:0];
                r.dir    = 1'b0;
                r.bounce = 1'b1;
            end else begin
                r.pos = pos + STEP;
            end
        end else begin
            if ({1'b0, pos} <= STEP_W) begin
                r.pos    = 10'd0;
                r.dir    = 1'b1;
                r.bounce = 1'b1;
            end else begin
                r.pos = pos - STEP;
            end
        end
        return r;
    endfunction

    // Candidate next position, box hit test and palette lookup.
    always_comb begin
        nxt_x  = step_axis(box_x, dir_x, X_LIM);
        nxt_y  = step_axis(box_y, dir_y, Y_LIM);
        in_box = ({1'b0, pix_x} >= {1'b0, box_x}) &&
                 ({1'b0, pix_x} <  {1'b0, box_x} + SIZE_W) &&
                 ({1'b0, pix_y} >= {1'b0, box_y}) &&
                 ({1'b0, pix_y} <  {1'b0, box_y} + SIZE_W);
        case (color_idx)
            3'd0:    box_color = 12'hF00;
            3'd1:    box_color = 12'h0F0;
            3'd2:    box_color = 12'h00F;
            3'd3:    box_color = 12'hFF0;
            3'd4:    box_color = 12'h0FF;
            3'd5:    box_color = 12'hF0F;
            3'd6:    box_color = 12'hFFF;
            default: box_color = 12'h888;
        endcase
    end

    // Pixel output and end-of-frame pulse; both run regardless of pause.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pix_data   <= 12'h000;
            frame_tick <= 1'b0;
        end else begin
            if (pix_x == NO_REQ || pix_y == NO_REQ)
                pix_data <= 12'h000;
            else if (in_box)
                pix_data <= box_color;
            else
                pix_data <= BG_COLOR;
            frame_tick <= (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);
        end
    end

    // Motion state only changes in the frame_tick cycle, so a frame never tears.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            box_x     <= 10'd0;
            box_y     <= 10'd0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            color_idx <= 3'd0;
        end else if (frame_tick && !pause) begin
            box_x <= nxt_x.pos;
            dir_x <= nxt_x.dir;
            box_y <= nxt_y.pos;
            dir_y <= nxt_y.dir;
            // A corner hit counts as a single colour step.
            if (nxt_x.bounce || nxt_y.bounce)
                color_idx <= color_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Directed bench for vga_pic_bounce: two instances (STEP=1 with a visible
// background colour, and STEP=BOX_SIZE=32), a reference motion model and a
// pixel scoreboard.
module tb_vga_pic_bounce;

    localparam int H = 640, V = 480, BOX = 32;
    localparam logic [11:0] BG_A = 12'h123;

    logic        vga_clk = 1'b0;
    logic        rst_a, rst_b, pause_a, pause_b;
    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [11:0] pd_a, pd_b;
    logic        ft_a, ft_b;
    logic [2:0]  ci_a, ci_b;

    int tests = 0, fails = 0, ticks_a = 0;
    logic [11:0] sb[$];

    // reference model state, index 0 = dut_a, 1 = dut_b
    int mx[2], my[2], mdx[2], mdy[2], mc[2];
    int step_of[2] = '{1, 32};
    logic [11:0] pal[8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                            12'h0FF, 12'hF0F, 12'hFFF, 12'h888};

    always #20 vga_clk = ~vga_clk;

    always @(posedge vga_clk) if (ft_a) ticks_a++;

    vga_pic_bounce #(.STEP(10'd1), .BG_COLOR(BG_A)) dut_a (
        .vga_clk(vga_clk), .sys_rst(rst_a), .pix_x(x_a), .pix_y(y_a),
        .pause(pause_a), .pix_data(pd_a), .frame_tick(ft_a), .color_idx(ci_a));

    vga_pic_bounce #(.STEP(10'd32)) dut_b (
        .vga_clk(vga_clk), .sys_rst(rst_b), .pix_x(x_b), .pix_y(y_b),
        .pause(pause_b), .pix_data(pd_b), .frame_tick(ft_b), .color_idx(ci_b));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic [9:0] x, input logic [9:0] y);
        if (s == 0) begin x_a = x; y_a = y; end
        else        begin x_b = x; y_b = y; end
    endtask

    task automatic model_reset(input int s);
        mx[s] = 0; my[s] = 0; mdx[s] = 1; mdy[s] = 1; mc[s] = 0;
    endtask

    // one axis of the reference motion; returns 1 on a wall hit
    function automatic bit move(inout int p, inout int d, input int lim, input int st);
        if (d == 1) begin
            if (p + st >= lim) begin p = lim; d = 0; return 1; end
            p = p + st;
        end else begin
            if (p <= st) begin p = 0; d = 1; return 1; end
            p = p - st;
        end
        return 0;
    endfunction

    task automatic model_tick(input int s);
        bit bx, by;
        int px, dx, py, dy;
        px = mx[s]; dx = mdx[s]; py = my[s]; dy = mdy[s];
        bx = move(px, dx, H - BOX, step_of[s]);
        by = move(py, dy, V - BOX, step_of[s]);
        mx[s] = px; mdx[s] = dx; my[s] = py; mdy[s] = dy;
        if (bx || by) mc[s] = (mc[s] + 1) % 8;
    endtask

    function automatic logic [11:0] exp_pix(input int s, input int x, input int y);
        if (x == 'h3FF || y == 'h3FF) return 12'h000;
        if (x >= mx[s] && x < mx[s] + BOX && y >= my[s] && y < my[s] + BOX)
            return pal[mc[s]];
        return (s == 0) ? BG_A : 12'h000;
    endfunction

    // request one pixel; expectation queued at drive, compared one cycle later
    task automatic req(input int s, input int x, input int y, input string tag);
        logic [11:0] got;
        @(negedge vga_clk);
        drive(s, x[9:0], y[9:0]);
        sb.push_back(exp_pix(s, x, y));
        @(posedge vga_clk); #1;
        got = (s == 0) ? pd_a : pd_b;
        check(tag, {4'h0, got}, {4'h0, sb.pop_front()});
        drive(s, 10'h3FF, 10'h3FF);
    endtask

    // n frame ends: last active pixel, then idle during the tick cycle
    task automatic ticks(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk); drive(s, 10'd639, 10'd479);
            @(negedge vga_clk); drive(s, 10'h3FF, 10'h3FF);
            if (!((s == 0) ? pause_a : pause_b)) model_tick(s);
        end
        @(negedge vga_clk);
    endtask

    task automatic check_state(input int s, input string tag);
        if (s == 0) begin
            check({tag, "_box_x"}, 16'(dut_a.box_x), 16'(mx[0]));
            check({tag, "_box_y"}, 16'(dut_a.box_y), 16'(my[0]));
            check({tag, "_dir_x"}, 16'(dut_a.dir_x), 16'(mdx[0]));
            check({tag, "_dir_y"}, 16'(dut_a.dir_y), 16'(mdy[0]));
            check({tag, "_color"}, 16'(ci_a), 16'(mc[0]));
        end else begin
            check({tag, "_box_x"}, 16'(dut_b.box_x), 16'(mx[1]));
            check({tag, "_box_y"}, 16'(dut_b.box_y), 16'(my[1]));
            check({tag, "_dir_x"}, 16'(dut_b.dir_x), 16'(mdx[1]));
            check({tag, "_dir_y"}, 16'(dut_b.dir_y), 16'(mdy[1]));
            check({tag, "_color"}, 16'(ci_b), 16'(mc[1]));
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; pause_a = 1'b0; pause_b = 1'b0;
        drive(0, 10'h3FF, 10'h3FF); drive(1, 10'h3FF, 10'h3FF);
        model_reset(0); model_reset(1);
        repeat (3) @(negedge vga_clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // reset state
        check("rst_pix", {4'h0, pd_a}, 16'h0000);
        check("rst_ft", 16'(ft_a), 16'h0);
        check("rst_box_x", 16'(dut_a.box_x), 16'd0);
        check("rst_box_y", 16'(dut_a.box_y), 16'd0);
        check("rst_dirs", {14'h0, dut_a.dir_x, dut_a.dir_y}, 16'h3);
        check("rst_color", 16'(ci_a), 16'd0);

        // basic pixel path
        req(0, 0, 0, "pix_0_0");
        check("pix_0_0_const", {4'h0, pd_a}, 16'h0F00);
        req(0, 32, 0, "pix_32_0");
        req(0, 31, 31, "pix_31_31");
        req(0, 31, 32, "pix_31_32");
        req(0, 'h3FF, 'h3FF, "pix_noreq");
        req(0, 5, 'h3FF, "pix_noreq_y");

        // a single frame end
        @(negedge vga_clk); drive(0, 10'd639, 10'd479);
        @(posedge vga_clk); #1;
        check("tick_hi", 16'(ft_a), 16'h1);
        @(negedge vga_clk); drive(0, 10'h3FF, 10'h3FF);
        model_tick(0);
        @(posedge vga_clk); #1;
        check("tick_one_cycle", 16'(ft_a), 16'h0);
        @(negedge vga_clk);
        check("t1_box_x", 16'(dut_a.box_x), 16'd1);
        check("t1_box_y", 16'(dut_a.box_y), 16'd1);
        req(0, 0, 0, "t1_pix_0_0");
        req(0, 1, 1, "t1_pix_1_1");
        check("t1_pix_1_1_const", {4'h0, pd_a}, 16'h0F00);

        // Y bounce at 448
        ticks(0, 447);
        check("y448_box_y", 16'(dut_a.box_y), 16'd448);
        check("y448_dir_y", 16'(dut_a.dir_y), 16'd0);
        check("y448_color", 16'(ci_a), 16'd1);
        check("y448_box_x", 16'(dut_a.box_x), 16'd448);
        check_state(0, "y448");
        req(0, 448, 448, "y448_pix_in");
        req(0, 447, 448, "y448_pix_out");

        // X bounce at 608
        ticks(0, 160);
        check("x608_box_x", 16'(dut_a.box_x), 16'd608);
        check("x608_dir_x", 16'(dut_a.dir_x), 16'd0);
        check("x608_color", 16'(ci_a), 16'd2);
        check_state(0, "x608");
        check("x608_ticks", 16'(ticks_a), 16'd608);
        req(0, 639, 319, "x608_pix_corner");
        req(0, 639, 320, "x608_pix_below");

        // pause holds motion but not ticks or pixels
        pause_a = 1'b1;
        ticks(0, 10);
        check_state(0, "pause");
        check("pause_ticks", 16'(ticks_a), 16'd618);
        req(0, 608, 288, "pause_pix");
        pause_a = 1'b0;
        ticks(0, 1);
        check("unpause_box_x", 16'(dut_a.box_x), 16'd607);
        check_state(0, "unpause");

        // STEP = BOX_SIZE = 32
        ticks(1, 18);
        check("b_box_x_576", 16'(dut_b.box_x), 16'd576);
        check("b_color_1", 16'(ci_b), 16'd1);
        check_state(1, "b18");
        ticks(1, 1);
        check("b_box_x_608", 16'(dut_b.box_x), 16'd608);
        check("b_dir_x_0", 16'(dut_b.dir_x), 16'd0);
        check("b_color_2", 16'(ci_b), 16'd2);
        ticks(1, 120);
        check_state(1, "b_long");
        req(1, mx[1], my[1], "b_pix_in");

        // reset coincident with a tick wins
        @(negedge vga_clk); drive(1, 10'd639, 10'd479);
        @(posedge vga_clk); #1;
        check("b_tick_hi", 16'(ft_b), 16'h1);
        @(negedge vga_clk); drive(1, 10'h3FF, 10'h3FF); rst_b = 1'b1;
        @(posedge vga_clk); #1;
        model_reset(1);
        check_state(1, "b_rst");
        check("b_rst_ft", 16'(ft_b), 16'h0);
        check("b_rst_pix", {4'h0, pd_b}, 16'h0000);
        @(negedge vga_clk); rst_b = 1'b0;
        req(1, 0, 0, "b_recover_pix");
        check("b_recover_const", {4'h0, pd_b}, 16'h0F00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_pic_bounce.md
VGA_PIC_BOUNCE -- requirements
Module: vga_pic_bounce

Interface
REQ-001 SHALL have parameter H_VALID, default 10'd640, active-area width in pixels.
REQ-002 SHALL have parameter V_VALID, default 10'd480, active-area height in pixels.
REQ-003 SHALL have parameter BOX_SIZE, default 10'd32, square box edge in pixels.
REQ-004 SHALL have parameter STEP, default 10'd1, box displacement per frame per axis; legal range 1..BOX_SIZE.
REQ-005 SHALL have parameter BG_COLOR, default 12'h000, background RGB444.
REQ-006 SHALL have port vga_clk, input, 1, pixel clock at 25 MHz; sole clock.
REQ-007 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port pix_x, input, 10, requested X coordinate; 10'h3FF = no request.
REQ-009 SHALL have port pix_y, input, 10, requested Y coordinate; 10'h3FF = no request.
REQ-010 SHALL have port pause, input, 1, freezes box motion while high.
REQ-011 SHALL have port pix_data, output, 12, RGB444 pixel for the previous cycle's coordinate.
REQ-012 SHALL have port frame_tick, output, 1, one-cycle pulse after the last active pixel of a frame.
REQ-013 SHALL have port color_idx, output, 3, current box palette index.

Function
REQ-014 SHALL register pix_data with exactly 1 cycle of latency from pix_x/pix_y, matching the one-cycle request lead of the downstream timing controller.
REQ-015 SHALL drive pix_data to 12'h000 when either coordinate at the prior cycle was 10'h3FF.
REQ-016 SHALL treat a coordinate as in-box when box_x <= pix_x < box_x+BOX_SIZE and box_y <= pix_y < box_y+BOX_SIZE, with the comparisons evaluated at 11 bits so there is no overflow.
REQ-017 SHALL output palette[color_idx] for in-box pixels and BG_COLOR otherwise.
REQ-018 SHALL use palette {0:12'hF00, 1:12'h0F0, 2:12'h00F, 3:12'hFF0, 4:12'h0FF, 5:12'hF0F, 6:12'hFFF, 7:12'h888}.
REQ-019 SHALL assert frame_tick for one cycle, on the cycle after pix_x==H_VALID-1 and pix_y==V_VALID-1 are sampled.
REQ-020 SHALL update box_x, box_y, dir_x, dir_y and color_idx only in the cycle where frame_tick is asserted and pause==0. The new position therefore applies from the next frame, and no frame ever tears.
REQ-021 SHALL move right (dir_x=1) as follows: if box_x+STEP >= H_VALID-BOX_SIZE, set box_x to H_VALID-BOX_SIZE, set dir_x to 0 and flag a bounce; otherwise box_x += STEP.
REQ-022 SHALL move left (dir_x=0) as follows: if box_x <= STEP, set box_x to 0, set dir_x to 1 and flag a bounce; otherwise box_x -= STEP.
REQ-023 SHALL apply identical rules on the Y axis, using V_VALID-BOX_SIZE and dir_y.
REQ-024 SHALL increment color_idx by 1 (modulo 8, 7 wraps to 0) on any bounce, and by exactly 1 when X and Y bounce in the same update (corner).
REQ-025 SHALL keep pix_data generation and frame_tick running while pause==1; only the motion state is held.
REQ-026 SHALL ignore pause changes except in the frame_tick cycle.

Reset
REQ-027 SHALL on sys_rst=1 at a vga_clk edge set pix_data=12'h000, frame_tick=0, box_x=0, box_y=0, dir_x=1, dir_y=1 and color_idx=0.
REQ-028 SHALL give reset priority over every update, including a coincident frame_tick.
REQ-029 SHALL recover from a mid-frame reset without any special sequencing, resuming normal output on the first cycle after reset deasserts.

Verification
REQ-030 SHALL be covered by this scenario: reset, then request (0,0) -> pix_data=12'hF00 one cycle later; request (32,0) -> 12'h000; request (3FF,3FF) -> 12'h000.
REQ-031 SHALL be covered by this scenario: drive (639,479) once -> frame_tick=1 for exactly one cycle, then box_x=1 and box_y=1; request (0,0) -> BG_COLOR, request (1,1) -> 12'hF00.
REQ-032 SHALL be covered by this scenario: 448 frame_ticks from reset -> box_y=448, dir_y=0, color_idx=1; box_x=448.
REQ-033 SHALL be covered by this scenario: 608 frame_ticks from reset -> box_x=608, dir_x=0; color_idx=2 after the Y bounce at 448 and the X bounce at 608.
REQ-034 SHALL be covered by this scenario: with pause=1 over 10 frame_ticks -> box_x, box_y and color_idx unchanged, and frame_tick still pulses 10 times.
REQ-035 SHALL be covered by this scenario: STEP=BOX_SIZE=32 with box_x=576 moving right, one tick -> box_x=608, dir_x=0, single color increment; sys_rst asserted together with a tick -> reset values.
